// File: rtl/dsram_pkg.sv
// Shared types and constants for the data-SRAM responder: word geometry,
// store byte-enable encodings and the response-pipeline entry.
package dsram_pkg;

  localparam int WORD_W      = 32;
  localparam int BYTE_LANES  = 4;
  localparam int LATENCY_MIN = 1;
  localparam int LATENCY_MAX = 4;

  localparam logic [BYTE_LANES-1:0] WE_WORD = 4'b1111;

  function automatic logic [BYTE_LANES-1:0] we_byte(input logic [1:0] lane);
    return 4'b0001 << lane;
  endfunction

  function automatic logic [BYTE_LANES-1:0] we_half(input logic [1:0] lane);
    return 4'b0011 << lane;
  endfunction

  typedef struct packed {
    logic              valid;
    logic              err;
    logic [WORD_W-1:0] data;
  } resp_t;

endpackage

// File: rtl/dsram_resp_pipe.sv
// Fixed-latency response shift register. The last stage only loads data on a
// valid read so the returned word stays on the output between responses.
module dsram_resp_pipe
  import dsram_pkg::*;
#(
  parameter int LATENCY = 1
) (
  input  logic  clk,
  input  logic  resetn,
  input  resp_t in_resp,
  output resp_t out_resp
);

  resp_t stage    [LATENCY];
  resp_t stage_in [LATENCY];

  // NOTE: every always_comb output gets a value on every path, otherwise a latch is inferred.
  always_comb begin
    stage_in[0] = in_resp;
    for (int i = 1; i < LATENCY; i++) stage_in[i] = stage[i-1];
  end

  // NOTE: sequential state uses non-blocking assignments so all stages shift on the same edge.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      for (int i = 0; i < LATENCY; i++) stage[i] <= '0;
    end else begin
      for (int i = 0; i < LATENCY; i++) begin
        stage[i].valid <= stage_in[i].valid;
        stage[i].err   <= stage_in[i].err;
        if (stage_in[i].valid || (i != LATENCY - 1)) stage[i].data <= stage_in[i].data;
      end
    end
  end

  assign out_resp = stage[LATENCY-1];

endmodule

// File: rtl/dsram_responder.sv
// Data-SRAM responder: word RAM with byte-masked writes and fixed-latency
// read responses. Define DSRAM_ACCESS_CNT_EN to build the rd_cnt/wr_cnt counters.
module dsram_responder
  import dsram_pkg::*;
#(
  parameter int          ADDR_W    = 10,
  parameter int          LATENCY   = 1,
  parameter logic [31:0] BASE_ADDR = 32'h0000_0000
) (
  input  logic                  clk,
  input  logic                  resetn,
  input  logic                  data_sram_en,
  input  logic [BYTE_LANES-1:0] data_sram_we,
  input  logic [31:0]           data_sram_addr,
  input  logic [WORD_W-1:0]     data_sram_wdata,
  output logic [WORD_W-1:0]     data_sram_rdata,
  output logic                  data_sram_rvalid,
  output logic                  data_sram_err,
  output logic [31:0]           rd_cnt,
  output logic [31:0]           wr_cnt
);

  if (LATENCY < LATENCY_MIN || LATENCY > LATENCY_MAX) begin : g_bad_latency
    $error("dsram_responder: LATENCY must be within 1..4");
  end

  localparam int unsigned DEPTH = 2 ** ADDR_W;
  localparam logic [32:0] SPAN  = 33'(DEPTH) << 2;

  logic [WORD_W-1:0] ram [DEPTH];

  logic [31:0]       off;
  logic              in_range;
  logic [ADDR_W-1:0] idx;
  logic              is_write;
  logic              is_read;
  resp_t             req_resp;
  resp_t             out_resp;

  assign off      = data_sram_addr - BASE_ADDR;
  assign in_range = {1'b0, off} < SPAN;
  assign idx      = off[ADDR_W+1:2];
  assign is_write = data_sram_en && (data_sram_we != '0);
  assign is_read  = data_sram_en && (data_sram_we == '0);

  // NOTE: RAM contents are deliberately not reset so the array maps onto block RAM.
  always_ff @(posedge clk) begin
    if (is_write && in_range) begin
      for (int i = 0; i < BYTE_LANES; i++) begin
        if (data_sram_we[i]) ram[idx][8*i +: 8] <= data_sram_wdata[8*i +: 8];
      end
    end
  end

  // Reads sample the array at the request edge; out-of-range accesses carry only err.
  always_comb begin
    req_resp = '0;
    if (is_read) begin
      req_resp.valid = 1'b1;
      req_resp.err   = !in_range;
      req_resp.data  = in_range ? ram[idx] : '0;
    end else if (is_write) begin
      req_resp.err = !in_range;
    end
  end

  dsram_resp_pipe #(
    .LATENCY (LATENCY)
  ) u_pipe (
    .clk      (clk),
    .resetn   (resetn),
    .in_resp  (req_resp),
    .out_resp (out_resp)
  );

  assign data_sram_rvalid = out_resp.valid;
  assign data_sram_err    = out_resp.err;
  assign data_sram_rdata  = out_resp.data;

`ifdef DSRAM_ACCESS_CNT_EN
  logic [31:0] rd_cnt_q;
  logic [31:0] wr_cnt_q;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      rd_cnt_q <= '0;
      wr_cnt_q <= '0;
    end else begin
      if (out_resp.valid) rd_cnt_q <= rd_cnt_q + 32'd1;
      if (is_write)       wr_cnt_q <= wr_cnt_q + 32'd1;
    end
  end

  assign rd_cnt = rd_cnt_q;
  assign wr_cnt = wr_cnt_q;
`else
  assign rd_cnt = '0;
  assign wr_cnt = '0;
`endif

endmodule

// File: tb/tb_dsram_responder.sv
// Directed bench for dsram_responder: one LATENCY=1 and one LATENCY=3 instance
// share the same request stream.
module tb_dsram_responder;
  import dsram_pkg::*;

  logic        clk;
  logic        resetn;
  logic        en;
  logic [3:0]  we;
  logic [31:0] addr;
  logic [31:0] wdata;

  logic [31:0] rdata1, rd_cnt1, wr_cnt1;
  logic        rvalid1, err1;
  logic [31:0] rdata3, rd_cnt3, wr_cnt3;
  logic        rvalid3, err3;

  int checks   = 0;
  int failures = 0;

  dsram_responder #(.ADDR_W(10), .LATENCY(1), .BASE_ADDR(32'h0)) dut (
    .clk              (clk),
    .resetn           (resetn),
    .data_sram_en     (en),
    .data_sram_we     (we),
    .data_sram_addr   (addr),
    .data_sram_wdata  (wdata),
    .data_sram_rdata  (rdata1),
    .data_sram_rvalid (rvalid1),
    .data_sram_err    (err1),
    .rd_cnt           (rd_cnt1),
    .wr_cnt           (wr_cnt1)
  );

  dsram_responder #(.ADDR_W(10), .LATENCY(3), .BASE_ADDR(32'h0)) dut3 (
    .clk              (clk),
    .resetn           (resetn),
    .data_sram_en     (en),
    .data_sram_we     (we),
    .data_sram_addr   (addr),
    .data_sram_wdata  (wdata),
    .data_sram_rdata  (rdata3),
    .data_sram_rvalid (rvalid3),
    .data_sram_err    (err3),
    .rd_cnt           (rd_cnt3),
    .wr_cnt           (wr_cnt3)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Inputs change at the falling edge; the call returns at the next falling edge.
  task automatic drive(input logic e, input logic [3:0] w, input logic [31:0] a, input logic [31:0] d);
    en = e; we = w; addr = a; wdata = d;
    @(negedge clk);
  endtask

  task automatic idle();
    drive(1'b0, 4'h0, 32'h0, 32'h0);
  endtask

  initial begin
    resetn = 1'b0;
    en = 1'b0; we = '0; addr = '0; wdata = '0;
    @(negedge clk);
    @(negedge clk);
    check("rst_rdata1",  rdata1,  32'h0);
    check("rst_rvalid1", 32'(rvalid1), 32'h0);
    check("rst_err1",    32'(err1),    32'h0);
    check("rst_rd_cnt1", rd_cnt1, 32'h0);
    check("rst_wr_cnt1", wr_cnt1, 32'h0);
    check("rst_rvalid3", 32'(rvalid3), 32'h0);
    resetn = 1'b1;
    @(negedge clk);

    // Byte-lane merge and latency
    drive(1'b1, WE_WORD, 32'h100, 32'h1122_3344);
    drive(1'b1, we_byte(2'd1), 32'h101, 32'hAAAA_AAAA);
    drive(1'b1, 4'h0, 32'h100, 32'h0);
    check("lane_rvalid1", 32'(rvalid1), 32'h1);
    check("lane_rdata1",  rdata1, 32'h1122_AA44);
    check("lane_rvalid3_c1", 32'(rvalid3), 32'h0);
    idle();
    check("lane_rvalid1_drop", 32'(rvalid1), 32'h0);
    check("lane_rdata1_hold",  rdata1, 32'h1122_AA44);
    check("lane_rvalid3_c2", 32'(rvalid3), 32'h0);
    idle();
    check("lane_rvalid3_c3", 32'(rvalid3), 32'h1);
    check("lane_rdata3",     rdata3, 32'h1122_AA44);
    idle();
    check("lane_rvalid3_c4", 32'(rvalid3), 32'h0);

    // Back-to-back reads
    for (int k = 0; k < 8; k++) drive(1'b1, WE_WORD, 32'(4 * k), 32'(k * 16));
    for (int k = 0; k < 8; k++) begin
      drive(1'b1, 4'h0, 32'(4 * k), 32'h0);
      check($sformatf("b2b_rvalid1_%0d", k), 32'(rvalid1), 32'h1);
      check($sformatf("b2b_rdata1_%0d", k), rdata1, 32'(k * 16));
      if (k >= 2) begin
        check($sformatf("b2b_rvalid3_%0d", k - 2), 32'(rvalid3), 32'h1);
        check($sformatf("b2b_rdata3_%0d", k - 2), rdata3, 32'((k - 2) * 16));
      end else begin
        check($sformatf("b2b_rvalid3_pre%0d", k), 32'(rvalid3), 32'h0);
      end
    end
    idle();
    check("b2b_rvalid1_end", 32'(rvalid1), 32'h0);
    check("b2b_rdata3_6",    rdata3, 32'h60);
    idle();
    check("b2b_rdata3_7",    rdata3, 32'h70);
    check("b2b_rvalid3_7",   32'(rvalid3), 32'h1);

    // Read-after-write
    drive(1'b1, WE_WORD, 32'h40, 32'hDEAD_BEEF);
    drive(1'b1, 4'h0, 32'h40, 32'h0);
    check("raw_rvalid1", 32'(rvalid1), 32'h1);
    check("raw_rdata1",  rdata1, 32'hDEAD_BEEF);
    idle(); idle(); idle();

    // Out-of-range read and write
    drive(1'b1, 4'h0, 32'h1000, 32'h0);
    check("oor_rd_rvalid1", 32'(rvalid1), 32'h1);
    check("oor_rd_err1",    32'(err1),    32'h1);
    check("oor_rd_rdata1",  rdata1, 32'h0);
    idle();
    check("oor_rd_err1_drop", 32'(err1), 32'h0);
    idle();
    check("oor_rd_err3",    32'(err3),    32'h1);
    check("oor_rd_rdata3",  rdata3, 32'h0);
    idle();
    drive(1'b1, WE_WORD, 32'h1000, 32'h5555_5555);
    check("oor_wr_err1",    32'(err1),    32'h1);
    check("oor_wr_rvalid1", 32'(rvalid1), 32'h0);
    idle();
    check("oor_wr_err1_drop", 32'(err1), 32'h0);
    idle();
    check("oor_wr_err3",    32'(err3),    32'h1);
    check("oor_wr_rvalid3", 32'(rvalid3), 32'h0);
    drive(1'b1, 4'h0, 32'h0, 32'h0);
    check("oor_wr_ram_word0", rdata1, 32'h0);
    check("oor_wr_ram_rvalid", 32'(rvalid1), 32'h1);
    idle(); idle(); idle();

    // Reset while a LATENCY=3 read is in flight
    drive(1'b1, 4'h0, 32'h100, 32'h0);
    resetn = 1'b0;
    en = 1'b0;
    #1;
    check("mid_rvalid3", 32'(rvalid3), 32'h0);
    check("mid_rdata1",  rdata1, 32'h0);
    check("mid_rvalid1", 32'(rvalid1), 32'h0);
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      check($sformatf("mid_hold_rvalid3_%0d", c), 32'(rvalid3), 32'h0);
      check($sformatf("mid_hold_err3_%0d", c),    32'(err3),    32'h0);
    end
    resetn = 1'b1;
    idle();
    check("mid_post_rvalid3", 32'(rvalid3), 32'h0);
    check("mid_post_rdata3",  rdata3, 32'h0);
    check("mid_post_rd_cnt1", rd_cnt1, 32'h0);
    check("mid_post_wr_cnt1", wr_cnt1, 32'h0);

    // RAM retention after reset plus counter traffic: 5 writes, 3 reads
    for (int k = 0; k < 5; k++) drive(1'b1, WE_WORD, 32'h200 + 32'(4 * k), 32'hC0DE_0000 + 32'(k));
    drive(1'b1, 4'h0, 32'h100, 32'h0);
    check("ret_rdata_100", rdata1, 32'h1122_AA44);
    drive(1'b1, 4'h0, 32'h40, 32'h0);
    check("ret_rdata_40", rdata1, 32'hDEAD_BEEF);
    drive(1'b1, 4'h0, 32'h204, 32'h0);
    check("cnt_rdata_204", rdata1, 32'hC0DE_0001);
    idle(); idle(); idle(); idle();
    check("cnt_rdata3_204", rdata3, 32'hC0DE_0001);
`ifdef DSRAM_ACCESS_CNT_EN
    check("cnt_wr_cnt1", wr_cnt1, 32'd5);
    check("cnt_rd_cnt1", rd_cnt1, 32'd3);
    check("cnt_rd_cnt3", rd_cnt3, 32'd3);

    force dut.rd_cnt_q = 32'hFFFF_FFFF;
    @(negedge clk);
    release dut.rd_cnt_q;
    check("wrap_preload", rd_cnt1, 32'hFFFF_FFFF);
    drive(1'b1, 4'h0, 32'h0, 32'h0);
    idle();
    check("wrap_rd_cnt1", rd_cnt1, 32'h0);
`else
    check("cnt_wr_cnt1_off", wr_cnt1, 32'h0);
    check("cnt_rd_cnt1_off", rd_cnt1, 32'h0);
    check("cnt_rd_cnt3_off", rd_cnt3, 32'h0);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
